// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 fetch definitions: opcodes, status codes,
//               register-none marker and fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        F_OP    = 3'd0,
        F_REG   = 3'd1,
        F_CONST = 3'd2,
        PRESENT = 3'd3,
        HALTED  = 3'd4
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/insn_len_decode.sv
// ============================================================================
// Module      : insn_len_decode
// Description : Combinational icode/ifun classifier giving instruction shape
//               and byte length. Optional macro: FETCH_IFUN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       need_regids,
    output logic       need_valc,
    output logic       insn_valid,
    output logic [3:0] length
);

    logic known;
    logic ifun_ok;
    logic regids_raw;
    logic valc_raw;

    always_comb begin
        known      = 1'b1;
        regids_raw = 1'b0;
        valc_raw   = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: ;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: regids_raw = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                regids_raw = 1'b1;
                valc_raw   = 1'b1;
            end
            I_JXX, I_CALL: valc_raw = 1'b1;
            default: known = 1'b0;
        endcase
    end

`ifdef FETCH_IFUN_CHECK_EN
    always_comb begin
        case (icode)
            I_RRMOVQ, I_JXX: ifun_ok = (ifun <= 4'd6);
            I_OPQ:           ifun_ok = (ifun <= 4'd3);
            default:         ifun_ok = (ifun == 4'd0);
        endcase
    end
`else
    logic unused_ifun;
    assign unused_ifun = ^ifun;
    assign ifun_ok     = 1'b1;
`endif

    // Invalid instructions fetch nothing beyond the opcode byte.
    assign insn_valid  = known & ifun_ok;
    assign need_regids = regids_raw & insn_valid;
    assign need_valc   = valc_raw & insn_valid;
    assign length      = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Multi-cycle byte-serial Y86-64 fetch with valid/ready output.
//               Optional macro: FETCH_IFUN_CHECK_EN (ifun validation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    input  logic        pc_load,
    input  logic [63:0] pc_new,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc_out,
    output logic [2:0]  stat,
    output logic        halted
);

    localparam logic [63:0] MEM_LIMIT = 64'(IMEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [63:0]  addr_q, addr_d;
    logic         req_q, req_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]   ra_q, ra_d, rb_q, rb_d;
    logic [63:0]  valc_q, valc_d, valp_q, valp_d, pc_out_q, pc_out_d;
    logic [2:0]   stat_q, stat_d;

    logic       dec_need_regids, dec_need_valc, dec_valid;
    logic [3:0] dec_len;
    logic [3:0] dec_icode, dec_ifun;
    logic       accept;
    logic       addr_bad;

    // The opcode is decoded straight off the bus in F_OP, from the latched copy after.
    assign dec_icode = (state_q == F_OP) ? imem_rdata[7:4] : icode_q;
    assign dec_ifun  = (state_q == F_OP) ? imem_rdata[3:0] : ifun_q;

    insn_len_decode u_len (
        .icode       (dec_icode),
        .ifun        (dec_ifun),
        .need_regids (dec_need_regids),
        .need_valc   (dec_need_valc),
        .insn_valid  (dec_valid),
        .length      (dec_len)
    );

    assign accept   = req_q & imem_ack;
    assign addr_bad = ~req_q & (addr_q >= MEM_LIMIT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        icode_d  = icode_q;
        ifun_d   = ifun_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        valc_d   = valc_q;
        valp_d   = valp_q;
        pc_out_d = pc_out_q;
        stat_d   = stat_q;

        case (state_q)
            F_OP: begin
                if (addr_bad) begin
                    icode_d  = 4'd0;
                    ifun_d   = 4'd0;
                    ra_d     = 4'd0;
                    rb_d     = 4'd0;
                    valc_d   = 64'd0;
                    pc_out_d = addr_q;
                    valp_d   = addr_q;
                    stat_d   = STAT_ADR;
                    state_d  = PRESENT;
                end else if (accept) begin
                    icode_d  = imem_rdata[7:4];
                    ifun_d   = imem_rdata[3:0];
                    pc_out_d = addr_q;
                    ra_d     = dec_need_regids ? 4'd0 : RNONE;
                    rb_d     = dec_need_regids ? 4'd0 : RNONE;
                    valc_d   = 64'd0;
                    valp_d   = addr_q + {60'd0, dec_len};
                    addr_d   = addr_q + 64'd1;
                    cnt_d    = 3'd0;
                    if (!dec_valid) begin
                        stat_d  = STAT_INS;
                        state_d = PRESENT;
                    end else if (dec_need_regids) begin
                        state_d = F_REG;
                    end else if (dec_need_valc) begin
                        state_d = F_CONST;
                    end else begin
                        stat_d  = (imem_rdata[7:4] == I_HALT) ? STAT_HLT : STAT_AOK;
                        state_d = PRESENT;
                    end
                end
            end
            F_REG, F_CONST: begin
                if (addr_bad) begin
                    stat_d  = STAT_ADR;
                    state_d = PRESENT;
                end else if (accept) begin
                    addr_d = addr_q + 64'd1;
                    if (state_q == F_REG) begin
                        ra_d    = imem_rdata[7:4];
                        rb_d    = imem_rdata[3:0];
                        cnt_d   = 3'd0;
                        state_d = dec_need_valc ? F_CONST : PRESENT;
                    end else begin
                        valc_d[{cnt_q, 3'b000} +: 8] = imem_rdata;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (stat_q == STAT_AOK) begin
                        addr_d  = valp_q;
                        state_d = F_OP;
                    end else begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: ;
            default: state_d = F_OP;
        endcase

        // A redirect wins over everything except a halted machine.
        if (pc_load && state_q != HALTED) begin
            addr_d  = pc_new;
            cnt_d   = 3'd0;
            stat_d  = STAT_AOK;
            state_d = F_OP;
        end

        req_d = (state_d == F_OP || state_d == F_REG || state_d == F_CONST) &&
                (addr_d < MEM_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= F_OP;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            cnt_q    <= 3'd0;
            icode_q  <= 4'd0;
            ifun_q   <= 4'd0;
            ra_q     <= 4'd0;
            rb_q     <= 4'd0;
            valc_q   <= 64'd0;
            valp_q   <= 64'd0;
            pc_out_q <= 64'd0;
            stat_q   <= STAT_AOK;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            icode_q  <= icode_d;
            ifun_q   <= ifun_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            valc_q   <= valc_d;
            valp_q   <= valp_d;
            pc_out_q <= pc_out_d;
            stat_q   <= stat_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = (state_q == PRESENT);
    assign halted    = (state_q == HALTED);
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign pc_out    = pc_out_q;
    assign stat      = stat_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard bench for fetch_sequencer with a byte-level
//               instruction model and randomized ack/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        pc_load;
    logic [63:0] pc_new;
    logic        out_valid, out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc_out;
    logic [2:0]  stat;
    logic        halted;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(64'd0), .IMEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_load(pc_load),
        .pc_new(pc_new), .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .valP(valP), .pc_out(pc_out), .stat(stat), .halted(halted)
    );

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pc;
        logic [2:0]  stat;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] mem [0:1023];
    int         n_acc;
    bit         ack_rand = 0, rdy_rand = 0;
    logic       ack_fix, rdy_fix, ack_r = 1'b1, rdy_r = 1'b1;

    assign imem_rdata = mem[imem_addr[9:0]];
    assign imem_ack   = ack_rand ? ack_r : ack_fix;
    assign out_ready  = rdy_rand ? rdy_r : rdy_fix;

    always @(posedge clk) begin
        if (rst) n_acc <= 0;
        else if (imem_req && imem_ack) n_acc <= n_acc + 1;
    end

    always @(posedge clk) begin
        #1;
        ack_r = ($urandom_range(0, 3) != 0);
        rdy_r = ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: decode one instruction at pc straight from the byte image.
    function automatic exp_t model_at(input logic [63:0] pc);
        exp_t        e;
        bit          has_reg, has_c, ok;
        logic [63:0] idx;
        int          len;
        e = '{icode: 0, ifun: 0, ra: 4'hF, rb: 4'hF, valc: 0, valp: 0, pc: pc, stat: STAT_AOK};
        e.icode = mem[pc[9:0]][7:4];
        e.ifun  = mem[pc[9:0]][3:0];
        has_reg = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        has_c   = e.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        ok      = (e.icode <= 4'hB);
`ifdef FETCH_IFUN_CHECK_EN
        if (e.icode == 4'h2 || e.icode == 4'h7) ok = ok && (e.ifun <= 4'd6);
        else if (e.icode == 4'h6)               ok = ok && (e.ifun <= 4'd3);
        else                                    ok = ok && (e.ifun == 4'd0);
`endif
        if (!ok) begin
            e.stat = STAT_INS;
            return e;
        end
        len    = 1 + (has_reg ? 1 : 0) + (has_c ? 8 : 0);
        e.valp = pc + 64'(len);
        if (has_reg) begin
            if (pc + 1 >= 1024) begin
                e.ra = 0; e.rb = 0; e.stat = STAT_ADR;
                return e;
            end
            e.ra = mem[pc[9:0] + 10'd1][7:4];
            e.rb = mem[pc[9:0] + 10'd1][3:0];
        end
        if (has_c) begin
            for (int k = 0; k < 8; k++) begin
                idx = pc + 1 + (has_reg ? 1 : 0) + 64'(k);
                if (idx >= 1024) begin
                    e.stat = STAT_ADR;
                    return e;
                end
                e.valc = e.valc | (64'(mem[idx[9:0]]) << (8 * k));
            end
        end
        if (e.icode == 4'h0) e.stat = STAT_HLT;
        return e;
    endfunction

    task automatic build_expect(input logic [63:0] start);
        logic [63:0] pc;
        exp_t        e;
        pc = start;
        for (int i = 0; i < 200; i++) begin
            e = model_at(pc);
            exp_q.push_back(e);
            if (e.stat != STAT_AOK) break;
            pc = e.valp;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic gen_program(input int n);
        logic [9:0] pc;
        logic [3:0] ic, fn;
        pc = 10'd0;
        for (int i = 0; i < n; i++) begin
            ic = 4'($urandom_range(1, 11));
            fn = (ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 6)) :
                 (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'd0;
            mem[pc] = {ic, fn}; pc++;
            if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
                mem[pc] = 8'($urandom); pc++;
            end
            if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
                for (int k = 0; k < 8; k++) begin mem[pc] = 8'($urandom); pc++; end
        end
        mem[pc] = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] a);
        pc_load = 1'b1; pc_new = a;
        @(posedge clk); #1 pc_load = 1'b0;
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1");
        end
    endtask

    task automatic wait_halted(input int budget, input logic [2:0] st);
        int cyc = 0;
        while (!halted && cyc < budget) begin @(negedge clk); cyc++; end
        chk("halt_reached", 64'(halted), 64'd1);
        chk("halt_stat", 64'(stat), 64'(st));
        chk("halt_req", 64'(imem_req), 64'd0);
        chk("halt_valid", 64'(out_valid), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every delivered instruction is compared against the next prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_insn: got pc %0h expected none", pc_out);
            end else begin
                e = exp_q.pop_front();
                chk("stat", 64'(stat), 64'(e.stat));
                chk("icode", 64'(icode), 64'(e.icode));
                chk("ifun", 64'(ifun), 64'(e.ifun));
                chk("rA", 64'(rA), 64'(e.ra));
                chk("rB", 64'(rB), 64'(e.rb));
                chk("valC", valC, e.valc);
                chk("pc_out", pc_out, e.pc);
                if (e.stat == STAT_AOK || e.stat == STAT_HLT) chk("valP", valP, e.valp);
            end
        end
    end

    initial begin
        rst = 1'b1; pc_load = 1'b0; pc_new = 64'd0; ack_fix = 1'b1; rdy_fix = 1'b1;
        clear_mem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_stat", 64'(stat), 64'(STAT_AOK));
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_rA", 64'(rA), 64'd0);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_pc_out", pc_out, 64'd0);

        // nop, halt
        mem[0] = 8'h10; mem[1] = 8'h00;
        build_expect(64'd0);
        do_reset();
        wait_halted(200, STAT_HLT);

        // irmovq at 0x10
        clear_mem();
        mem[16] = 8'h30; mem[17] = 8'hF3;
        for (int k = 0; k < 8; k++) mem[18 + k] = 8'h88 - 8'(k * 8'h11);
        mem[26] = 8'h00;
        build_expect(64'h10);
        do_reset();
        redirect(64'h10);
        wait_halted(200, STAT_HLT);

        // invalid opcode
        clear_mem();
        mem[0] = 8'hC0;
        build_expect(64'd0);
        do_reset();
        wait_halted(200, STAT_INS);
        chk("ins_bytes", 64'(n_acc), 64'd1);

        // jmp running off the end of memory
        clear_mem();
        mem[1020] = 8'h70; mem[1021] = 8'hAB; mem[1022] = 8'hCD; mem[1023] = 8'hEF;
        build_expect(64'h3FC);
        do_reset();
        redirect(64'h3FC);
        wait_halted(200, STAT_ADR);
        chk("adr_bytes", 64'(n_acc), 64'd4);

        // redirect during third byte of rmmovq
        clear_mem();
        mem[0] = 8'h40; mem[1] = 8'h12;
        for (int k = 2; k < 10; k++) mem[k] = 8'(k);
        mem[64] = 8'h10; mem[65] = 8'h00;
        build_expect(64'h40);
        do_reset();
        for (int c = 0; c < 50 && n_acc != 2; c++) begin @(posedge clk); #1; end
        redirect(64'h40);
        @(negedge clk);
        chk("redir_addr", imem_addr, 64'h40);
        chk("redir_req", 64'(imem_req), 64'd1);
        wait_halted(200, STAT_HLT);

        // redirect coinciding with a handshake
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'hC0; mem[64] = 8'h00;
        exp_q.push_back(model_at(64'd0));
        exp_q.push_back(model_at(64'h40));
        rdy_fix = 1'b0;
        do_reset();
        wait_valid();
        rdy_fix = 1'b1;
        redirect(64'h40);
        wait_halted(200, STAT_HLT);

        // backpressure then memory stall
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h00;
        build_expect(64'd0);
        rdy_fix = 1'b0;
        do_reset();
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_req", 64'(imem_req), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_valP", valP, 64'd1);
        end
        @(posedge clk); #1 rdy_fix = 1'b1; ack_fix = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_addr", imem_addr, 64'd1);
            chk("stall_bytes", 64'(n_acc), 64'd1);
        end
        @(posedge clk); #1 ack_fix = 1'b1;
        wait_halted(200, STAT_HLT);

        // OPq with an out-of-range function code
        clear_mem();
        mem[0] = 8'h67; mem[1] = 8'h12; mem[2] = 8'h00;
        build_expect(64'd0);
        do_reset();
`ifdef FETCH_IFUN_CHECK_EN
        wait_halted(200, STAT_INS);
`else
        wait_halted(200, STAT_HLT);
`endif

        // random programs with random ack/ready
        for (int r = 0; r < 3; r++) begin
            clear_mem();
            gen_program(25);
            build_expect(64'd0);
            ack_rand = 1; rdy_rand = 1;
            do_reset();
            wait_halted(3000, STAT_HLT);
            ack_rand = 0; rdy_rand = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle Y86-64 fetch controller sitting between the PC-select logic and the byte-wide instruction memory. It walks the PC through memory one byte per accepted request, splits the bytes into icode/ifun/rA/rB/valC and computes valP. It hands each complete instruction to decode over a valid/ready handshake and stops the machine on halt, invalid instruction or address error.

## Interface
- `RESET_PC`, default 0: PC loaded on reset.
- `IMEM_BYTES`, default 1024: instruction memory size; valid byte addresses are 0..IMEM_BYTES-1.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `imem_req  out  1`: byte read request.
- `imem_addr  out  64`: byte address; stable while `imem_req` is high.
- `imem_ack  in  1`: request accepted this cycle; `imem_rdata` is valid in the same cycle.
- `imem_rdata  in  8`: read byte.
- `pc_load  in  1`: redirect strobe.
- `pc_new  in  64`: redirect target.
- `out_valid  out  1` / `out_ready  in  1`: handshake to decode.
- `icode`, `ifun`, `rA`, `rB`  out  4 each: decoded fields.
- `valC  out  64`, `valP  out  64`, `pc_out  out  64`: constant, next PC, and instruction address.
- `stat  out  3`: AOK=1, HLT=2, ADR=3, INS=4.
- `halted  out  1`: sequencer stopped.

## Operation
- States: `F_OP`, `F_REG`, `F_CONST`, `PRESENT`, `HALTED`.
- **Reset:**
  - State goes to `F_OP` with PC=`RESET_PC`.
  - `imem_req`, `out_valid`, `halted` reset to 0.
  - All field outputs, `valC`, `valP`, `pc_out` reset to 0; `stat` resets to 1 (AOK).
- **`F_OP`:**
  - Requests the byte at PC. On ack: icode=rdata[7:4], ifun=rdata[3:0], pc_out=PC.
  - Length by icode:
    - 0, 1, 9 → 1 byte.
    - 2, 6, A, B → 2 bytes (regids).
    - 3, 4, 5 → 10 bytes (regids + valC).
    - 7, 8 → 9 bytes (valC only).
    - icode > B → stat INS; go to `PRESENT` with no further bytes.
- **`F_REG`:** rA=rdata[7:4], rB=rdata[3:0].
- **`F_CONST`:** 3-bit byte counter 0..7; byte k goes to valC[8k+7:8k] (little-endian). The counter resets on entry to the state.
- **valC/rA/rB defaults:** fields not fetched for the current icode are driven to 0. rA/rB use 4'hF when there are no regids.
- **valP:** pc_out + length, 64-bit modular (wraps silently).
- **Address check:** if the next byte address is ≥ `IMEM_BYTES`, no request is issued. stat=ADR and the state goes to `PRESENT`. Fields fetched so far are kept; the rest are 0.
- **`PRESENT`:**
  - `out_valid`=1 with all outputs held stable until `out_ready`.
  - On handshake with stat AOK: PC←valP, next state `F_OP`.
  - On handshake with stat HLT (icode 0), ADR or INS: next state `HALTED`.
- **`HALTED`:** `halted`=1, `imem_req`=0, `out_valid`=0; `stat` holds the terminating code. Only `rst` leaves this state; `pc_load` is ignored.
- **`pc_load`** (any state except `HALTED`):
  - PC←pc_new and the next state is `F_OP`.
  - Any partially fetched instruction is discarded and stat returns to AOK.
  - If it coincides with a `PRESENT` handshake, the instruction is still delivered; the next PC is pc_new, not valP.
  - `rst` has priority over `pc_load`.

## Timing
- One byte per cycle when `imem_ack` is tied high. Byte data is sampled at the clock edge where req&ack.
- An N-byte instruction takes N cycles of requests. `out_valid` rises the cycle after the last byte is accepted, so the minimum is N+1 cycles per instruction.
- `imem_req` stays low in `PRESENT` and `HALTED`.
- Outputs are registered; there is no combinational path from `out_ready` to any output.

## Configuration
- `FETCH_IFUN_CHECK_EN` defined: ifun is validated in `F_OP`.
  - Allowed: icode 2/7 need ifun ≤ 6, icode 6 needs ifun ≤ 3, all other icodes need ifun = 0.
  - A violation gives stat INS and goes to `PRESENT` immediately.
- Undefined: ifun is passed through unchecked; only icode > B raises INS.

## Structure
- `y86_pkg` holds:
  - icode constants (I_HALT..I_POPQ);
  - stat codes (STAT_AOK/HLT/ADR/INS);
  - the RNONE=4'hF constant;
  - the FSM state enum.
- Sub-module `insn_len_decode`: combinational, icode (+ifun) → need_regids, need_valC, insn_valid, length[3:0]. It is shared later with the pipelined fetch.

## Test plan
- **nop then halt** at 0: bytes 10 00, ack high.
  - Instruction 1: out_valid in cycle 1, icode=1, valP=1, stat=1.
  - Instruction 2: out_valid in cycle 3, icode=0, stat=2; then halted=1, imem_req=0.
- **irmovq at 0x10:** bytes 30 F3 88 77 66 55 44 33 22 11 → rA=F, rB=3, valC=0x1122334455667788, valP=0x1A, out_valid at cycle 10.
- **Invalid opcode:** byte C0 → stat=4 after 1 byte, no further requests, halted after handshake.
- **Address error:** jmp at 0x3FC with IMEM_BYTES=1024 → 4 bytes requested (0x3FC..0x3FF), stat=3, halted.
- **Redirect:** pc_load=1 with pc_new=0x40 during the third byte of rmmovq → partial fetch discarded, next imem_addr=0x40. The same redirect during a `PRESENT` handshake delivers the instruction, then fetches at 0x40.
- **Backpressure and stall:** out_ready low for 5 cycles → outputs stable, no requests; imem_ack low for 3 cycles → imem_addr held and no byte consumed.
- **With `FETCH_IFUN_CHECK_EN`:** byte 67 (OPq fn 7) → stat=4. Without it → stat=1, ifun=7.
